muldiv_alu_control_unit: RTL and testbench
==========================================

Name: muldiv_alu_control_unit

Overview:
- Hardwired Moore control unit that drives the datapath control strobes directly from a state register.
- Per instruction: fetches it, decodes opcode/register fields from IR, sequences mul/div, three-register ALU ops and neg/not, then returns to fetch.
- Replaces hand-coded strobe sequencing with one clocked FSM and adds a memory-ready wait and a fault state.

Parameters:
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready in T1 before FAULT; 0 disables the timeout.
- NUM_REGS, 16, number of general registers; width of the one-hot register selects.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-high reset
- run  in  1  permit instruction start; sampled only in IDLE
- mem_ready  in  1  memory read data valid on m_data_in this cycle
- ir  in  32  datapath IR contents: opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15]
- pc_out, zlo_out, zhi_out, mdr_out  out  1 each  bus drive strobes
- mar_enable, pc_enable, mdr_enable, ir_enable, y_enable, z_enable, lo_enable, hi_enable  out  1 each  register load strobes
- pc_increment  out  1  ALU computes bus+1 into Z
- read  out  1  MDR mux selects memory data
- op_code  out  5  ALU operation
- reg_out_sel  out  NUM_REGS  one-hot general-register bus drive
- reg_in_sel  out  NUM_REGS  one-hot general-register load
- instr_done  out  1  one-cycle pulse on the last execute step
- fault  out  1  high while in FAULT

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT. One step per clk cycle except T1. All outputs are decoded only from the state register and latched IR fields.
- Reset: clr high forces IDLE asynchronously. Every output is 0, op_code=5'b00000, selects all-zero. Reset mid-instruction abandons it; no strobe survives past the clr edge.
- IDLE: all outputs 0. run=1 -> T0, otherwise stay.
- T0: pc_out, mar_enable, pc_increment, z_enable. -> T1.
- T1: zlo_out, pc_enable asserted on the first T1 cycle only; read held every T1 cycle; mdr_enable only in cycles with mem_ready=1.
  - mem_ready=1 -> T2.
  - Wait counter increments on each T1 cycle with mem_ready=0. If it reaches MEM_TIMEOUT (MEM_TIMEOUT!=0) -> FAULT.
- T2: mdr_out, ir_enable. -> T3. IR is captured this edge and decoded from T3 on.
- mul (10000) / div (01111):
  - T3: reg_out_sel[ra], y_enable.
  - T4: reg_out_sel[rb], op_code=opcode, z_enable.
  - T5: zlo_out, lo_enable.
  - T6: zhi_out, hi_enable, instr_done. -> IDLE.
- add..shl (00011-01011):
  - T3: reg_out_sel[rb], y_enable.
  - T4: reg_out_sel[rc], op_code, z_enable.
  - T5: zlo_out, reg_in_sel[ra], instr_done. -> IDLE.
- neg (10001) / not (10010):
  - T3: reg_out_sel[rb], op_code, z_enable.
  - T4: zlo_out, reg_in_sel[ra], instr_done. -> IDLE.
- Any other opcode, including ld/ldi/st/addi/andi/ori and 10011-11111: T3 -> FAULT. No strobes in T3.
- FAULT: fault=1, all other outputs 0; exit only via clr.
- op_code is non-zero only in the Z-capture step; 0 elsewhere.
- Register fields index [3:0]; field >= NUM_REGS -> FAULT at T3.
- Invariants, every cycle: at most one bus driver among pc_out, zlo_out, zhi_out, mdr_out and reg_out_sel bits; reg_out_sel and reg_in_sel each at most one-hot.
- Back-to-back: run held high re-enters T0 the cycle after IDLE. IDLE always lasts at least one cycle.

Test Plan:
- mul R2,R6: run=1, mem_ready=1 in T1, ir=0x81300000 -> order T0,T1,T2,T3(reg_out_sel=0x0004,y_enable),T4(reg_out_sel=0x0040,op_code=10000,z_enable),T5(zlo_out,lo_enable),T6(zhi_out,hi_enable,instr_done); 7 active cycles.
- add R1,R2,R3: ir=0x18918000 -> T3 reg_out_sel=0x0004; T4 reg_out_sel=0x0008, op_code=00011; T5 reg_in_sel=0x0002 with instr_done.
- Memory wait: mem_ready low 3 cycles then high -> T1 lasts 4 cycles; pc_enable in the first only; mdr_enable in the 4th only. Low for 15 cycles -> fault=1 and stays high.
- Illegal opcode ir=0xF8000000 -> FAULT after T3; no register or LO/HI load strobe is ever asserted.
- clr pulse asserted in T4 of a div -> all outputs 0 immediately, state IDLE; with run=1 the next fetch restarts at T0.
- Continuous run=1 over 3 neg instructions (ir=0x88880000) -> each T3 op_code=10001, reg_out_sel=0x0002; each T4 reg_in_sel=0x0002; instr_done pulses 3 times, spaced 6 cycles apart.

Source files
------------

// File: rtl/muldiv_alu_control_unit.sv
// Hardwired Moore control unit: fetch, decode and sequence mul/div, three-register ALU ops and neg/not.
// Strobes are decoded from the state register and the IR fields latched while in T3.
module muldiv_alu_control_unit #(
   parameter int MEM_TIMEOUT = 15,
   parameter int NUM_REGS    = 16
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                run,
   input  logic                mem_ready,
   input  logic [31:0]         ir,
   output logic                pc_out,
   output logic                zlo_out,
   output logic                zhi_out,
   output logic                mdr_out,
   output logic                mar_enable,
   output logic                pc_enable,
   output logic                mdr_enable,
   output logic                ir_enable,
   output logic                y_enable,
   output logic                z_enable,
   output logic                lo_enable,
   output logic                hi_enable,
   output logic                pc_increment,
   output logic                read,
   output logic [4:0]          op_code,
   output logic [NUM_REGS-1:0] reg_out_sel,
   output logic [NUM_REGS-1:0] reg_in_sel,
   output logic                instr_done,
   output logic                fault
);

   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_FAULT
   } state_t;

   typedef enum logic [1:0] {
      C_BAD,
      C_MULDIV,
      C_ALU3,
      C_UNARY
   } class_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   wait_cnt;
   logic            t1_first;
   logic            timeout_hit;

   logic [4:0]      ir_opc;
   logic [3:0]      ir_ra;
   logic [3:0]      ir_rb;
   logic [3:0]      ir_rc;
   class_t          ir_cls;
   logic            ir_unused;

   logic [4:0]      opc_q;
   logic [3:0]      ra_q;
   logic [3:0]      rb_q;
   logic [3:0]      rc_q;
   class_t          cls_q;

   logic [4:0]      cur_opc;
   logic [3:0]      cur_ra;
   logic [3:0]      cur_rb;
   logic [3:0]      cur_rc;
   class_t          cur_cls;

   function automatic logic field_ok(input logic [3:0] f);
      return int'(f) < NUM_REGS;
   endfunction

   function automatic logic [NUM_REGS-1:0] sel(input logic [3:0] f);
      return NUM_REGS'(1) << f;
   endfunction

   // Only opcodes with a full execute sequence and in-range register fields are legal.
   function automatic class_t classify(input logic [4:0] opc, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
      class_t cl;
      cl = C_BAD;
      if (opc == 5'b10000 || opc == 5'b01111) begin
         if (field_ok(a) && field_ok(b)) cl = C_MULDIV;
      end else if (opc >= 5'b00011 && opc <= 5'b01011) begin
         if (field_ok(a) && field_ok(b) && field_ok(c)) cl = C_ALU3;
      end else if (opc == 5'b10001 || opc == 5'b10010) begin
         if (field_ok(a) && field_ok(b)) cl = C_UNARY;
      end
      return cl;
   endfunction

   assign ir_opc    = ir[31:27];
   assign ir_ra     = ir[26:23];
   assign ir_rb     = ir[22:19];
   assign ir_rc     = ir[18:15];
   assign ir_unused = ^ir[14:0];
   assign ir_cls    = classify(ir_opc, ir_ra, ir_rb, ir_rc);

   // The datapath IR settles at the T2 edge; T3 decodes it live, later steps use the copy taken in T3.
   assign cur_opc = (state == S_T3) ? ir_opc : opc_q;
   assign cur_ra  = (state == S_T3) ? ir_ra  : ra_q;
   assign cur_rb  = (state == S_T3) ? ir_rb  : rb_q;
   assign cur_rc  = (state == S_T3) ? ir_rc  : rc_q;
   assign cur_cls = (state == S_T3) ? ir_cls : cls_q;

   // mem_ready acts as a data-valid: the read is held in T1 until a cycle with mem_ready=1,
   // which loads MDR in that same cycle and advances to T2; there is no back-pressure toward memory.
   assign t1_first    = (wait_cnt == '0);
   assign timeout_hit = (MEM_TIMEOUT != 0) && ((int'(wait_cnt) + 1) == MEM_TIMEOUT);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wait_cnt <= '0;
      end else if (state != S_T1) begin
         wait_cnt <= '0;
      end else if (!mem_ready && wait_cnt != '1) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         opc_q <= '0;
         ra_q  <= '0;
         rb_q  <= '0;
         rc_q  <= '0;
         cls_q <= C_BAD;
      end else if (state == S_T3) begin
         opc_q <= ir_opc;
         ra_q  <= ir_ra;
         rb_q  <= ir_rb;
         rc_q  <= ir_rc;
         cls_q <= ir_cls;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (run) state_nxt = S_T0;
         S_T0:    state_nxt = S_T1;
         S_T1: begin
            if (mem_ready) begin
               state_nxt = S_T2;
            end else if (timeout_hit) begin
               state_nxt = S_FAULT;
            end
         end
         S_T2:    state_nxt = S_T3;
         S_T3:    state_nxt = (cur_cls == C_BAD) ? S_FAULT : S_T4;
         S_T4:    state_nxt = (cur_cls == C_UNARY) ? S_IDLE : S_T5;
         S_T5:    state_nxt = (cur_cls == C_ALU3) ? S_IDLE : S_T6;
         S_T6:    state_nxt = S_IDLE;
         S_FAULT: state_nxt = S_FAULT;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pc_out       = 1'b0;
      zlo_out      = 1'b0;
      zhi_out      = 1'b0;
      mdr_out      = 1'b0;
      mar_enable   = 1'b0;
      pc_enable    = 1'b0;
      mdr_enable   = 1'b0;
      ir_enable    = 1'b0;
      y_enable     = 1'b0;
      z_enable     = 1'b0;
      lo_enable    = 1'b0;
      hi_enable    = 1'b0;
      pc_increment = 1'b0;
      read         = 1'b0;
      op_code      = 5'b00000;
      reg_out_sel  = '0;
      reg_in_sel   = '0;
      instr_done   = 1'b0;
      fault        = 1'b0;
      case (state)
         S_T0: begin
            pc_out       = 1'b1;
            mar_enable   = 1'b1;
            pc_increment = 1'b1;
            z_enable     = 1'b1;
         end
         S_T1: begin
            read       = 1'b1;
            mdr_enable = mem_ready;
            if (t1_first) begin
               zlo_out   = 1'b1;
               pc_enable = 1'b1;
            end
         end
         S_T2: begin
            mdr_out   = 1'b1;
            ir_enable = 1'b1;
         end
         S_T3: begin
            case (cur_cls)
               C_MULDIV: begin
                  reg_out_sel = sel(cur_ra);
                  y_enable    = 1'b1;
               end
               C_ALU3: begin
                  reg_out_sel = sel(cur_rb);
                  y_enable    = 1'b1;
               end
               C_UNARY: begin
                  reg_out_sel = sel(cur_rb);
                  op_code     = cur_opc;
                  z_enable    = 1'b1;
               end
               default: ;
            endcase
         end
         S_T4: begin
            case (cur_cls)
               C_MULDIV: begin
                  reg_out_sel = sel(cur_rb);
                  op_code     = cur_opc;
                  z_enable    = 1'b1;
               end
               C_ALU3: begin
                  reg_out_sel = sel(cur_rc);
                  op_code     = cur_opc;
                  z_enable    = 1'b1;
               end
               C_UNARY: begin
                  zlo_out    = 1'b1;
                  reg_in_sel = sel(cur_ra);
                  instr_done = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (cur_cls)
               C_MULDIV: begin
                  zlo_out   = 1'b1;
                  lo_enable = 1'b1;
               end
               C_ALU3: begin
                  zlo_out    = 1'b1;
                  reg_in_sel = sel(cur_ra);
                  instr_done = 1'b1;
               end
               default: ;
            endcase
         end
         S_T6: begin
            zhi_out    = 1'b1;
            hi_enable  = 1'b1;
            instr_done = 1'b1;
         end
         S_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_muldiv_alu_control_unit.sv
// Directed and random instructions checked cycle by cycle against an instruction-level model
// that expands each instruction into its expected strobe pattern.
module tb_muldiv_alu_control_unit;

   localparam int NR = 16;
   localparam int TO = 15;

   typedef struct packed {
      logic          pc_out;
      logic          zlo_out;
      logic          zhi_out;
      logic          mdr_out;
      logic          mar_enable;
      logic          pc_enable;
      logic          mdr_enable;
      logic          ir_enable;
      logic          y_enable;
      logic          z_enable;
      logic          lo_enable;
      logic          hi_enable;
      logic          pc_increment;
      logic          read;
      logic          instr_done;
      logic          fault;
      logic [4:0]    op_code;
      logic [NR-1:0] rout;
      logic [NR-1:0] rin;
   } ctl_t;

   localparam int W = $bits(ctl_t);

   logic          clk = 1'b0;
   logic          clr;
   logic          run;
   logic          mem_ready;
   logic [31:0]   ir;
   logic          pc_out, zlo_out, zhi_out, mdr_out;
   logic          mar_enable, pc_enable, mdr_enable, ir_enable;
   logic          y_enable, z_enable, lo_enable, hi_enable;
   logic          pc_increment, read, instr_done, fault;
   logic [4:0]    op_code;
   logic [NR-1:0] reg_out_sel, reg_in_sel;
   ctl_t          act;

   logic [W-1:0]  exp_q[$];
   logic          mr_q[$];
   logic [31:0]   ir_q[$];
   string         tag_q[$];
   int            done_cyc[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic          cur_mr;
   logic [31:0]   cur_ir;
   string         cur_tag;

   muldiv_alu_control_unit #(.MEM_TIMEOUT(TO), .NUM_REGS(NR)) dut (
      .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
      .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
      .mar_enable(mar_enable), .pc_enable(pc_enable), .mdr_enable(mdr_enable), .ir_enable(ir_enable),
      .y_enable(y_enable), .z_enable(z_enable), .lo_enable(lo_enable), .hi_enable(hi_enable),
      .pc_increment(pc_increment), .read(read), .op_code(op_code),
      .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel),
      .instr_done(instr_done), .fault(fault)
   );

   // clock / cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      act              = '0;
      act.pc_out       = pc_out;
      act.zlo_out      = zlo_out;
      act.zhi_out      = zhi_out;
      act.mdr_out      = mdr_out;
      act.mar_enable   = mar_enable;
      act.pc_enable    = pc_enable;
      act.mdr_enable   = mdr_enable;
      act.ir_enable    = ir_enable;
      act.y_enable     = y_enable;
      act.z_enable     = z_enable;
      act.lo_enable    = lo_enable;
      act.hi_enable    = hi_enable;
      act.pc_increment = pc_increment;
      act.read         = read;
      act.instr_done   = instr_done;
      act.fault        = fault;
      act.op_code      = op_code;
      act.rout         = reg_out_sel;
      act.rin          = reg_in_sel;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed no end of test, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // scoreboard
   task automatic check_ctl(input string tag, input logic [W-1:0] exp_v);
      ctl_t e;
      e = exp_v;
      checks++;
      assert (act === e) else begin
         errors++;
         $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, act, e);
      end
      checks++;
      assert ($countones({act.pc_out, act.zlo_out, act.zhi_out, act.mdr_out, act.rout}) <= 1 &&
              $countones(act.rin) <= 1) else begin
         errors++;
         $error("FAIL %s_onehot cyc %0d: observed drivers %h loads %h expected at most one each",
                tag, cyc, {act.pc_out, act.zlo_out, act.zhi_out, act.mdr_out, act.rout}, act.rin);
      end
      if (act.instr_done === 1'b1) done_cyc.push_back(cyc);
   endtask

   // driver tasks
   task automatic push(input ctl_t c);
      exp_q.push_back(c);
      mr_q.push_back(cur_mr);
      ir_q.push_back(cur_ir);
      tag_q.push_back(cur_tag);
   endtask

   task automatic step();
      logic [W-1:0] e;
      string t;
      @(negedge clk);
      mem_ready = mr_q.pop_front();
      ir        = ir_q.pop_front();
      e         = exp_q.pop_front();
      t         = tag_q.pop_front();
      #1;
      check_ctl(t, e);
   endtask

   task automatic run_n(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic run_all();
      while (exp_q.size() > 0) step();
   endtask

   task automatic flush();
      exp_q.delete();
      mr_q.delete();
      ir_q.delete();
      tag_q.delete();
   endtask

   task automatic pulse_clr(input string tag);
      clr = 1'b1;
      #1;
      check_ctl(tag, '0);
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   task automatic push_fault(input int n);
      ctl_t c;
      for (int k = 0; k < n; k++) begin
         c = '0;
         c.fault = 1'b1;
         cur_mr = 1'($urandom_range(0, 1));
         push(c);
      end
   endtask

   // Reference model: expands one instruction (one IDLE cycle, fetch with n_wait stalls, execute).
   task automatic model_instr(input logic [31:0] i_ir, input int n_wait, input string name,
                              output bit faulted);
      ctl_t c;
      int   op, ra, rb, rc;
      op = int'(i_ir[31:27]);
      ra = int'(i_ir[26:23]);
      rb = int'(i_ir[22:19]);
      rc = int'(i_ir[18:15]);
      faulted = 1'b0;
      cur_ir  = i_ir;
      cur_tag = name;
      c = '0;
      cur_mr = 1'($urandom_range(0, 1));
      push(c);
      c = '0;
      c.pc_out = 1'b1; c.mar_enable = 1'b1; c.pc_increment = 1'b1; c.z_enable = 1'b1;
      cur_mr = 1'($urandom_range(0, 1));
      push(c);
      if (TO != 0 && n_wait >= TO) begin
         for (int k = 0; k < TO; k++) begin
            c = '0;
            c.read = 1'b1;
            if (k == 0) begin c.zlo_out = 1'b1; c.pc_enable = 1'b1; end
            cur_mr = 1'b0;
            push(c);
         end
         push_fault(3);
         faulted = 1'b1;
         return;
      end
      for (int k = 0; k <= n_wait; k++) begin
         c = '0;
         c.read = 1'b1;
         if (k == 0) begin c.zlo_out = 1'b1; c.pc_enable = 1'b1; end
         cur_mr = (k == n_wait);
         c.mdr_enable = cur_mr;
         push(c);
      end
      cur_mr = 1'($urandom_range(0, 1));
      c = '0;
      c.mdr_out = 1'b1; c.ir_enable = 1'b1;
      push(c);
      if ((op == 16 || op == 15) && ra < NR && rb < NR) begin
         c = '0; c.rout = NR'(1) << ra; c.y_enable = 1'b1; push(c);
         c = '0; c.rout = NR'(1) << rb; c.op_code = 5'(op); c.z_enable = 1'b1; push(c);
         c = '0; c.zlo_out = 1'b1; c.lo_enable = 1'b1; push(c);
         c = '0; c.zhi_out = 1'b1; c.hi_enable = 1'b1; c.instr_done = 1'b1; push(c);
      end else if (op >= 3 && op <= 11 && ra < NR && rb < NR && rc < NR) begin
         c = '0; c.rout = NR'(1) << rb; c.y_enable = 1'b1; push(c);
         c = '0; c.rout = NR'(1) << rc; c.op_code = 5'(op); c.z_enable = 1'b1; push(c);
         c = '0; c.zlo_out = 1'b1; c.rin = NR'(1) << ra; c.instr_done = 1'b1; push(c);
      end else if ((op == 17 || op == 18) && ra < NR && rb < NR) begin
         c = '0; c.rout = NR'(1) << rb; c.op_code = 5'(op); c.z_enable = 1'b1; push(c);
         c = '0; c.zlo_out = 1'b1; c.rin = NR'(1) << ra; c.instr_done = 1'b1; push(c);
      end else begin
         c = '0;
         push(c);
         push_fault(3);
         faulted = 1'b1;
      end
   endtask

   initial begin
      bit          f;
      logic [31:0] rnd;
      logic [4:0]  op;
      int          sel_r, w, n_wait;
      clr = 1'b1;
      run = 1'b0;
      mem_ready = 1'b0;
      ir = '0;
      repeat (2) @(posedge clk);
      #1;
      check_ctl("reset", '0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      run = 1'b1;

      model_instr(32'h8130_0000, 0, "mul_r2_r6", f);
      run_all();
      model_instr(32'h1891_8000, 0, "add_r1_r2_r3", f);
      run_all();
      model_instr(32'h8888_0000, 3, "neg_wait3", f);
      run_all();
      model_instr(32'h8130_0000, TO - 1, "wait_limit_ok", f);
      run_all();
      model_instr(32'h8130_0000, TO, "mem_timeout", f);
      run_all();
      pulse_clr("timeout_clr");
      model_instr(32'hF800_0000, 0, "illegal_op", f);
      run_all();
      pulse_clr("illegal_clr");

      model_instr(32'h7930_0000, 0, "div_abort", f);
      run_n(6);
      flush();
      pulse_clr("div_abort_clr");
      model_instr(32'h7930_0000, 1, "div_restart", f);
      run_all();

      done_cyc.delete();
      for (int k = 0; k < 3; k++) model_instr(32'h8888_0000, 0, "neg_b2b", f);
      run_all();
      checks++;
      assert (done_cyc.size() == 3) else begin
         errors++;
         $error("FAIL neg_done_count: observed %0d expected 3", done_cyc.size());
      end
      for (int k = 1; k < done_cyc.size(); k++) begin
         checks++;
         assert (done_cyc[k] - done_cyc[k-1] == 6) else begin
            errors++;
            $error("FAIL neg_done_spacing: observed %0d expected 6", done_cyc[k] - done_cyc[k-1]);
         end
      end

      for (int i = 0; i < 40; i++) begin
         sel_r = $urandom_range(0, 9);
         case (sel_r)
            0:       op = 5'b10000;
            1:       op = 5'b01111;
            2, 3, 4, 5: op = 5'($urandom_range(3, 11));
            6:       op = 5'b10001;
            7:       op = 5'b10010;
            default: op = 5'($urandom_range(0, 31));
         endcase
         w = $urandom_range(0, 9);
         n_wait = (w == 8) ? TO - 1 : (w == 9) ? TO : (w % 4);
         rnd = $urandom();
         model_instr({op, rnd[26:0]}, n_wait, "random", f);
         run_all();
         if (f) pulse_clr("random_clr");
      end

      run = 1'b0;
      cur_ir = 32'h8130_0000;
      cur_tag = "idle_hold";
      for (int k = 0; k < 3; k++) begin
         cur_mr = 1'($urandom_range(0, 1));
         push('0);
      end
      run_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
